// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan decoder: mode encoding, enable
// combination and the active-low one-hot decode.
package scan_decoder_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the decode helper supports; callers size-cast the result.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT   = 2 ** MAX_SEL_W;

    function automatic logic scan_enable(input logic e1, input logic e2_n, input logic e3_n);
        return e1 & ~e2_n & ~e3_n;
    endfunction

    function automatic logic [MAX_OUT-1:0] onehot_n(input logic [MAX_SEL_W-1:0] index);
        return ~(MAX_OUT'(1) << index);
    endfunction

endpackage

// File: rtl/scan_decoder_prescaler.sv
// Free-running DIV-cycle counter that advances only while run is high and
// flags the last count of each period with step.
module scan_prescaler #(
    parameter int DIV   = 50000,
    parameter int DIV_W = $clog2(DIV + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic step
);

    logic [DIV_W-1:0] count;

    assign step = run && (count == DIV_W'(DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (run) begin
            count <= step ? '0 : count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered SEL_W-to-2^SEL_W active-low decoder with a manual select mode
// and a prescaled auto-scan mode for multiplexed digit/bank selects.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int SCAN_LAST = 2 ** SEL_W - 1,
    parameter int DIV       = 50000,
    parameter int DIV_W     = $clog2(DIV + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  e1,
    input  logic                  e2_n,
    input  logic                  e3_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   y_n,
    output logic [SEL_W-1:0]      idx,
    output logic                  tick
);

    localparam int OUT_N = 2 ** SEL_W;

    logic             en;
    logic             run;
    logic             step;
    logic [SEL_W-1:0] scan_cnt;
    logic [SEL_W-1:0] scan_adv;
    logic [SEL_W-1:0] next_idx;

    scan_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .step (step)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        en       = scan_enable(e1, e2_n, e3_n);
        run      = en && (mode == MODE_SCAN);
        scan_adv = (scan_cnt == SEL_W'(SCAN_LAST)) ? '0 : scan_cnt + SEL_W'(1);
        next_idx = sel;
        // Use the advanced count on the step edge so y_n, idx and tick move together.
        if (mode == MODE_SCAN) begin
            next_idx = step ? scan_adv : scan_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_n      <= '1;
            idx      <= '0;
            tick     <= 1'b0;
            scan_cnt <= '0;
        end else begin
            if (step) begin
                scan_cnt <= scan_adv;
            end
            tick <= step;
            idx  <= next_idx;
            y_n  <= en ? OUT_N'(onehot_n(MAX_SEL_W'(next_idx))) : '1;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: table-driven enable/manual vectors
// plus directed scan, pause/resume, reset and mode-switch sequences.
module tb_scan_decoder;

    localparam int SEL_W     = 3;
    localparam int SCAN_LAST = 5;
    localparam int DIV       = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       e1;
    logic       e2_n;
    logic       e3_n;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] y_n;
    logic [2:0] idx;
    logic       tick;

    int checks = 0;
    int errors = 0;

    // Reference model state for the scan sequences
    int m_pre = 0;
    int m_idx = 0;

    typedef struct {
        logic       e1;
        logic       e2_n;
        logic       e3_n;
        logic [2:0] sel;
        logic [7:0] exp_y;
    } vec_t;

    vec_t vecs[16];

    scan_decoder #(
        .SEL_W     (SEL_W),
        .SCAN_LAST (SCAN_LAST),
        .DIV       (DIV)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .e1   (e1),
        .e2_n (e2_n),
        .e3_n (e3_n),
        .mode (mode),
        .sel  (sel),
        .y_n  (y_n),
        .idx  (idx),
        .tick (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges while predicting prescaler, index, y_n and tick.
    task automatic scan_edges(input int n);
        logic       run_m;
        logic       stp;
        logic [7:0] exp_y;
        for (int i = 0; i < n; i++) begin
            run_m = e1 && !e2_n && !e3_n && mode;
            stp   = run_m && (m_pre == DIV - 1);
            if (run_m) m_pre = stp ? 0 : m_pre + 1;
            if (stp) m_idx = (m_idx == SCAN_LAST) ? 0 : m_idx + 1;
            exp_y = (e1 && !e2_n && !e3_n) ? ~(8'b1 << m_idx) : 8'hFF;
            clk_edge();
            check("scan_idx", 32'(idx), 32'(m_idx));
            check("scan_y_n", 32'(y_n), 32'(exp_y));
            check("scan_tick", 32'(tick), 32'(stp));
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'd5, 8'hFF};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 3'd5, 8'hFF};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'd5, 8'hFF};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 3'd5, 8'hFF};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'd5, 8'hDF};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 3'd5, 8'hFF};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'd5, 8'hFF};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 3'd5, 8'hFF};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'hFE};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'd1, 8'hFD};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 3'd2, 8'hFB};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 3'd3, 8'hF7};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 3'd4, 8'hEF};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 3'd5, 8'hDF};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 3'd6, 8'hBF};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 3'd7, 8'h7F};

        // Reset / idle
        rst = 1'b1; e1 = 1'b0; e2_n = 1'b0; e3_n = 1'b0; mode = 1'b0; sel = 3'd0;
        clk_edge();
        clk_edge();
        check("reset_y_n", 32'(y_n), 32'hFF);
        check("reset_idx", 32'(idx), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);

        // Enable truth table and manual sweep
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e1   = vecs[i].e1;
            e2_n = vecs[i].e2_n;
            e3_n = vecs[i].e3_n;
            sel  = vecs[i].sel;
            clk_edge();
            check($sformatf("vec%0d_y_n", i), 32'(y_n), 32'(vecs[i].exp_y));
            check($sformatf("vec%0d_idx", i), 32'(idx), 32'(vecs[i].sel));
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'd0);
        end

        // Scan wrap 0..5,0 from a fresh reset
        rst = 1'b1;
        clk_edge();
        rst = 1'b0; mode = 1'b1; e1 = 1'b1; e2_n = 1'b0; e3_n = 1'b0;
        m_pre = 0; m_idx = 0;
        scan_edges(DIV * (SCAN_LAST + 1));
        check("wrap_back_to_0", 32'(idx), 32'd0);

        // Reach idx=2, leave a nonzero prescaler value, then pause
        scan_edges(2 * DIV + 1);
        check("pause_start_idx", 32'(idx), 32'd2);
        e1 = 1'b0;
        scan_edges(10);
        e1 = 1'b1;
        scan_edges(DIV - 1);
        check("resume_next_idx", 32'(idx), 32'd3);

        // Run to idx=4 within a bounded number of edges
        for (int i = 0; i < 40 && m_idx != 4; i++) scan_edges(1);
        check("reached_idx4", 32'(idx), 32'd4);

        // Mid-scan reset
        rst = 1'b1;
        clk_edge();
        check("midrst_idx", 32'(idx), 32'd0);
        check("midrst_y_n", 32'(y_n), 32'hFF);
        check("midrst_tick", 32'(tick), 32'd0);
        rst = 1'b0;
        m_pre = 0; m_idx = 0;
        scan_edges(DIV);
        check("midrst_first_step", 32'(idx), 32'd1);

        // Mode switch to manual
        mode = 1'b0; sel = 3'd7;
        clk_edge();
        check("manual_y_n", 32'(y_n), 32'h7F);
        check("manual_idx", 32'(idx), 32'd7);
        check("manual_tick", 32'(tick), 32'd0);
        for (int i = 0; i < 2 * DIV; i++) begin
            clk_edge();
            check("manual_tick_hold", 32'(tick), 32'd0);
        end
        check("manual_y_n_hold", 32'(y_n), 32'h7F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
